// File: rtl/ibex_rf_spill_mem.sv
// Word-addressed backing SRAM answering the Ibex data-bus protocol.
// Holds spilled register files; responds with fixed latency and bounds
// the number of accepted-but-unanswered requests.
module ibex_rf_spill_mem #(
    parameter int unsigned NumWords       = 512,
    parameter logic [31:0] BaseAddr       = 32'h0010_0000,
    parameter int unsigned RespLatency    = 1,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic        idle_o
);

    localparam int unsigned IdxW = (NumWords > 1) ? $clog2(NumWords) : 1;
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    logic [31:0]          mem_q [NumWords];
    logic [31:0]          offset;
    logic [31:0]          word_idx;
    logic [IdxW-1:0]      mem_idx;
    logic                 in_range;
    logic                 accept;
    logic                 rvalid;
    logic [31:0]          rd_word;

    logic [CntW-1:0]      count_q, count_d;
    logic [RespLatency-1:0] vld_q;
    logic [RespLatency-1:0] err_q;
    logic [31:0]          rdata_q [RespLatency];

    // Address decode: unsigned wrap makes addresses below the base land out of range
    assign offset   = data_addr_i - BaseAddr;
    assign word_idx = offset >> 2;
    assign in_range = word_idx < 32'(NumWords);
    assign mem_idx  = word_idx[IdxW-1:0];

    // Grant depends only on registered occupancy and reset
    assign data_gnt_o = !rst_i && (count_q < CntW'(MaxOutstanding));
    assign accept     = data_req_i && data_gnt_o;
    assign rvalid     = vld_q[RespLatency-1];

    // Response payload captured at the accept edge; writes and errors return zero
    assign rd_word = (data_we_i || !in_range) ? 32'h0 : mem_q[mem_idx];

    // Occupancy: accepts add, visible responses retire
    always_comb begin
        count_d = count_q;
        if (accept && !rvalid) begin
            count_d = count_q + CntW'(1);
        end else if (!accept && rvalid) begin
            count_d = count_q - CntW'(1);
        end
    end

    // Backing store with per-byte write enables; contents survive reset
    always_ff @(posedge clk_i) begin
        if (accept && data_we_i && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (data_be_i[b]) begin
                    mem_q[mem_idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Fixed-latency response pipeline and occupancy counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
            vld_q   <= '0;
            err_q   <= '0;
            for (int i = 0; i < int'(RespLatency); i++) begin
                rdata_q[i] <= '0;
            end
        end else begin
            count_q    <= count_d;
            vld_q[0]   <= accept;
            err_q[0]   <= accept && !in_range;
            rdata_q[0] <= accept ? rd_word : 32'h0;
            for (int i = 1; i < int'(RespLatency); i++) begin
                vld_q[i]   <= vld_q[i-1];
                err_q[i]   <= err_q[i-1];
                rdata_q[i] <= rdata_q[i-1];
            end
        end
    end

    assign data_rvalid_o = rvalid;
    assign data_rdata_o  = rdata_q[RespLatency-1];
    assign data_err_o    = err_q[RespLatency-1];
    assign idle_o        = (count_q == '0);

endmodule

// File: tb/tb_ibex_rf_spill_mem.sv
// Bench for ibex_rf_spill_mem: two instances (latency 1 and latency 3),
// a transaction-level model per instance, and directed scenarios.
module tb_ibex_rf_spill_mem;

    localparam logic [31:0] BASE = 32'h0010_0000;
    localparam int unsigned NW   = 512;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rst, req, we, gnt, rvalid, err, idle;
    logic [1:0][3:0]  be;
    logic [1:0][31:0] addr, wdata, rdata;

    int nchk = 0;
    int nerr = 0;

    logic [31:0] log_rd [2][256];
    logic        log_er [2][256];
    int          log_n  [2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    generate
        for (genvar k = 0; k < 2; k++) begin : g_inst
            localparam int unsigned LAT  = (k == 0) ? 1 : 3;
            localparam int unsigned MAXO = 2;

            ibex_rf_spill_mem #(
                .NumWords(NW), .BaseAddr(BASE),
                .RespLatency(LAT), .MaxOutstanding(MAXO)
            ) dut (
                .clk_i(clk), .rst_i(rst[k]),
                .data_req_i(req[k]), .data_gnt_o(gnt[k]),
                .data_rvalid_o(rvalid[k]), .data_we_i(we[k]),
                .data_be_i(be[k]), .data_addr_i(addr[k]),
                .data_wdata_i(wdata[k]), .data_rdata_o(rdata[k]),
                .data_err_o(err[k]), .idle_o(idle[k])
            );

            typedef struct {
                int          due;
                logic [31:0] rd;
                logic        er;
            } resp_t;

            resp_t       q[$];
            logic [31:0] mem [NW];
            int          e    = 0;
            bit          seen = 1'b0;

            // Model: pending responses, each due at (accept edge + latency)
            always @(posedge clk) begin : model
                int unsigned idx;
                bit          acc;
                resp_t       r;
                e++;
                if (rst[k]) begin
                    q.delete();
                    seen = 1'b1;
                end else begin
                    acc = req[k] && (q.size() < int'(MAXO));
                    if (q.size() > 0 && q[0].due == e) void'(q.pop_front());
                    if (acc) begin
                        idx   = (addr[k] - BASE) >> 2;
                        r.due = e + int'(LAT);
                        r.rd  = 32'h0;
                        r.er  = 1'b0;
                        if (idx >= NW) begin
                            r.er = 1'b1;
                        end else if (we[k]) begin
                            for (int b = 0; b < 4; b++)
                                if (be[k][b]) mem[idx][8*b +: 8] = wdata[k][8*b +: 8];
                        end else begin
                            r.rd = mem[idx];
                        end
                        q.push_back(r);
                    end
                end
            end

            // Cycle-by-cycle comparison against the model, plus response log
            always @(negedge clk) begin : cmp
                logic        ev;
                logic [31:0] erd;
                logic        eer;
                if (seen) begin
                    ev  = (q.size() > 0) && (q[0].due == e + 1);
                    erd = ev ? q[0].rd : 32'h0;
                    eer = ev ? q[0].er : 1'b0;
                    chk($sformatf("gnt%0d", k),    32'(gnt[k]),    32'(!rst[k] && q.size() < int'(MAXO)));
                    chk($sformatf("rvalid%0d", k), 32'(rvalid[k]), 32'(ev));
                    chk($sformatf("rdata%0d", k),  rdata[k],       erd);
                    chk($sformatf("err%0d", k),    32'(err[k]),    32'(eer));
                    chk($sformatf("idle%0d", k),   32'(idle[k]),   32'(q.size() == 0));
                    if (rvalid[k] && log_n[k] < 256) begin
                        log_rd[k][log_n[k]] = rdata[k];
                        log_er[k][log_n[k]] = err[k];
                        log_n[k]++;
                    end
                end
            end
        end
    endgenerate

    task automatic issue(input int k, input logic w, input logic [3:0] b,
                         input logic [31:0] a, input logic [31:0] d);
        logic g;
        req[k] = 1'b1; we[k] = w; be[k] = b; addr[k] = a; wdata[k] = d;
        for (int i = 0; i < 50; i++) begin
            #1;
            g = gnt[k];
            @(posedge clk);
            #2;
            if (g) return;
        end
        nchk++; nerr++;
        $display("FAIL issue_timeout inst%0d: no grant within 50 cycles", k);
    endtask

    task automatic wait_idle(input int k);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #2;
            if (idle[k]) return;
        end
        nchk++; nerr++;
        $display("FAIL idle_timeout inst%0d: idle not reached within 50 cycles", k);
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int          bn;
        int          acc_n;
        logic [7:0]  pat;
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; req[k] = 1'b0; we[k] = 1'b0; be[k] = 4'h0;
            addr[k] = '0; wdata[k] = '0; log_n[k] = 0;
        end
        @(posedge clk);
        #2;
        cycles(2);
        rst = 2'b00;
        #1;
        chk("reset_gnt", 32'(gnt[0]), 32'd1);
        chk("reset_idle", 32'(idle[0]), 32'd1);
        chk("reset_rvalid", 32'(rvalid[1]), 32'd0);
        chk("reset_rdata", rdata[1], 32'h0);

        // Write then read, latency 1
        bn = log_n[0];
        issue(0, 1'b1, 4'hF, BASE + 32'h7C, 32'hDEAD_BEEF);
        issue(0, 1'b0, 4'hF, BASE + 32'h7C, 32'h0);
        req[0] = 1'b0;
        wait_idle(0);
        chk("wr_rd_count", 32'(log_n[0] - bn), 32'd2);
        chk("wr_resp_rdata", log_rd[0][bn], 32'h0);
        chk("wr_resp_err", 32'(log_er[0][bn]), 32'd0);
        chk("rd_resp_rdata", log_rd[0][bn+1], 32'hDEAD_BEEF);

        // Byte-enable merge
        bn = log_n[0];
        issue(0, 1'b1, 4'hF,    BASE + 32'h100, 32'h1122_3344);
        issue(0, 1'b1, 4'b0101, BASE + 32'h100, 32'hAABB_CCDD);
        issue(0, 1'b0, 4'h0,    BASE + 32'h100, 32'h0);
        req[0] = 1'b0;
        wait_idle(0);
        chk("be_merge", log_rd[0][bn+2], 32'h11BB_33DD);

        // Out of range: writes and reads at both ends must not touch memory
        bn = log_n[0];
        issue(0, 1'b1, 4'hF, BASE,                 32'hCAFE_0000);
        issue(0, 1'b1, 4'hF, BASE + 32'(4*(NW-1)), 32'h5151_5151);
        issue(0, 1'b1, 4'hF, BASE + 32'(4*NW),     32'hFFFF_FFFF);
        issue(0, 1'b1, 4'hF, BASE - 32'd4,         32'hEEEE_EEEE);
        issue(0, 1'b0, 4'hF, BASE + 32'(4*NW),     32'h0);
        issue(0, 1'b0, 4'hF, BASE - 32'd4,         32'h0);
        issue(0, 1'b0, 4'hF, BASE + 32'(4*(NW-1)), 32'h0);
        issue(0, 1'b0, 4'hF, BASE,                 32'h0);
        req[0] = 1'b0;
        wait_idle(0);
        chk("oor_wr_err", 32'(log_er[0][bn+2]), 32'd1);
        chk("oor_hi_err", 32'(log_er[0][bn+4]), 32'd1);
        chk("oor_hi_rdata", log_rd[0][bn+4], 32'h0);
        chk("oor_lo_err", 32'(log_er[0][bn+5]), 32'd1);
        chk("oor_lo_rdata", log_rd[0][bn+5], 32'h0);
        chk("oor_last_word", log_rd[0][bn+6], 32'h5151_5151);
        chk("oor_first_word", log_rd[0][bn+7], 32'hCAFE_0000);

        // Backpressure, latency 3, two outstanding
        for (int i = 0; i < 4; i++) issue(1, 1'b1, 4'hF, BASE + 32'(4*i), 32'h100 + 32'(i));
        req[1] = 1'b0;
        wait_idle(1);
        bn = log_n[1];
        acc_n = 0;
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = BASE;
        for (int i = 0; i < 8; i++) begin
            #1;
            pat[i] = gnt[1];
            @(posedge clk);
            #2;
            if (pat[i]) begin
                acc_n++;
                addr[1] = BASE + 32'(4*acc_n);
            end
        end
        req[1] = 1'b0;
        wait_idle(1);
        chk("bp_gnt_pattern", 32'(pat), 32'h33);
        chk("bp_resp_count", 32'(log_n[1] - bn), 32'd4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("bp_order%0d", i), log_rd[1][bn+i], 32'h100 + 32'(i));

        // Reset with two reads in flight
        bn = log_n[1];
        issue(1, 1'b0, 4'hF, BASE,         32'h0);
        issue(1, 1'b0, 4'hF, BASE + 32'd4, 32'h0);
        req[1] = 1'b0;
        rst[1] = 1'b1;
        cycles(1);
        rst[1] = 1'b0;
        #1;
        chk("midrst_gnt", 32'(gnt[1]), 32'd1);
        chk("midrst_idle", 32'(idle[1]), 32'd1);
        cycles(6);
        chk("midrst_no_rvalid", 32'(log_n[1] - bn), 32'd0);

        // Full register-file swap on file A
        bn = log_n[0];
        for (int i = 0; i < 32; i++) issue(0, 1'b1, 4'hF, BASE + 32'h80 + 32'(4*i), 32'(i + 1));
        for (int i = 0; i < 32; i++) issue(0, 1'b0, 4'hF, BASE + 32'h80 + 32'(4*i), 32'h0);
        req[0] = 1'b0;
        wait_idle(0);
        chk("swap_count", 32'(log_n[0] - bn), 32'd64);
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("swap_rd%0d", i), log_rd[0][bn+32+i], 32'(i + 1));
            chk($sformatf("swap_err%0d", i), 32'(log_er[0][bn+32+i]), 32'd0);
        end
        chk("swap_idle", 32'(idle[0]), 32'd1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
